// File: rtl/quad_encoder_pkg.sv
// Shared definitions for the quadrature encoder front end.
//   quad_state_t        : debounced {A,B} phase state (S00/S10/S11/S01)
//   DIR_INC / DIR_DEC   : step_dir encoding
//   SUBSTEPS_PER_DETENT : quadrature edges making up one detent
//   SUBSTEP_W/substep_t : signed sub-step counter
//   quad_fwd/quad_rev   : neighbours of a state in the increment sequence
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } quad_state_t;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam int SUBSTEPS_PER_DETENT = 4;
  localparam int SUBSTEP_W           = 3;

  typedef logic signed [SUBSTEP_W-1:0] substep_t;

  // Successor in the increment (A leads) sequence S00->S10->S11->S01->S00.
  function automatic quad_state_t quad_fwd(input quad_state_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

  // Successor in the decrement (B leads) sequence.
  function automatic quad_state_t quad_rev(input quad_state_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_if.sv
// Bundle of per-channel encoder inputs and decoded outputs.
//   master : drives raw phases/switch and clear, receives decoded results
//   slave  : the encoder array itself
interface quad_encoder_if #(
  parameter int CHANNELS    = 2,
  parameter int COUNT_WIDTH = 8
);

  logic [CHANNELS-1:0]             enc_phase_a;
  logic [CHANNELS-1:0]             enc_phase_b;
  logic [CHANNELS-1:0]             enc_switch;
  logic [CHANNELS-1:0]             clear;
  logic [CHANNELS*COUNT_WIDTH-1:0] position;
  logic [CHANNELS-1:0]             step_valid;
  logic [CHANNELS-1:0]             step_dir;
  logic [CHANNELS-1:0]             press;
  logic [CHANNELS-1:0]             switch_level;
  logic [CHANNELS-1:0]             quad_err;
  logic [CHANNELS-1:0]             at_limit;

  modport master (
    output enc_phase_a, enc_phase_b, enc_switch, clear,
    input  position, step_valid, step_dir, press, switch_level, quad_err, at_limit
  );

  modport slave (
    input  enc_phase_a, enc_phase_b, enc_switch, clear,
    output position, step_valid, step_dir, press, switch_level, quad_err, at_limit
  );

endinterface

// File: rtl/quad_encoder_channel.sv
// One encoder channel: 2-FF synchroniser, tick-based debouncer, quadrature
// FSM with signed sub-step counter, and detent position counter.
// Ports:
//   clk100Mhz, reset         : clock, synchronous active-high reset
//   tick                     : shared sample enable for the debouncer
//   enc_phase_a/b, enc_switch: raw asynchronous inputs
//   clear                    : synchronous position clear
//   position                 : detent counter
//   step_valid/step_dir      : detent strobe and its direction (held)
//   press/switch_level       : switch rising-edge strobe / debounced level
//   quad_err                 : illegal two-bit transition strobe
//   at_limit                 : position at a bound (saturating build only)
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE        = 0
) (
  input  logic                   clk100Mhz,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   enc_phase_a,
  input  logic                   enc_phase_b,
  input  logic                   enc_switch,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] position,
  output logic                   step_valid,
  output logic                   step_dir,
  output logic                   press,
  output logic                   switch_level,
  output logic                   quad_err,
  output logic                   at_limit
);

  localparam int RUN_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] POS_MAX = '1;

  localparam int IDX_A  = 0;
  localparam int IDX_B  = 1;
  localparam int IDX_SW = 2;

  // One extra bit so the +/-4 reached on the final edge is representable.
  localparam int SUB_WIDE_W = SUBSTEP_W + 1;
  localparam logic signed [SUB_WIDE_W-1:0] DETENT_FWD = SUB_WIDE_W'(SUBSTEPS_PER_DETENT);
  localparam logic signed [SUB_WIDE_W-1:0] DETENT_REV = -DETENT_FWD;

  function automatic logic [COUNT_WIDTH-1:0] pos_up(input logic [COUNT_WIDTH-1:0] p);
    if ((SATURATE != 0) && (p == POS_MAX)) return p;
    return p + 1'b1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] pos_down(input logic [COUNT_WIDTH-1:0] p);
    if ((SATURATE != 0) && (p == '0)) return p;
    return p - 1'b1;
  endfunction

  logic [2:0]       raw_bits;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       deb_p2;
  logic [RUN_W-1:0] run_cnt [3];

  assign raw_bits = {enc_switch, enc_phase_b, enc_phase_a};

  // ---- stage p0/p1: synchroniser; stage p2: debounced levels ----
  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      for (int i = 0; i < 3; i++) run_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw_bits;
      sync_p1 <= sync_p0;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          if (sync_p1[i] == deb_p2[i]) begin
            run_cnt[i] <= '0;
          end else if (run_cnt[i] == RUN_LAST) begin
            deb_p2[i]  <= sync_p1[i];
            run_cnt[i] <= '0;
          end else begin
            run_cnt[i] <= run_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  quad_state_t                  state_q, state_d;
  substep_t                     sub_q, sub_d;
  logic signed [SUB_WIDE_W-1:0] sub_delta, sub_wide;
  logic                         is_fwd, is_rev, is_illegal, enter_s00;
  logic                         detent_inc, detent_dec;
  logic [COUNT_WIDTH-1:0]       pos_d;
  logic                         dir_d, at_limit_d;
  logic                         sw_prev;

  // Next state: FSM always adopts the debounced phases; the transition kind
  // decides how the sub-step counter moves.
  always_comb begin
    state_d    = quad_state_t'({deb_p2[IDX_A], deb_p2[IDX_B]});
    is_fwd     = (state_d == quad_fwd(state_q));
    is_rev     = (state_d == quad_rev(state_q));
    is_illegal = (state_d != state_q) && !is_fwd && !is_rev;
    sub_delta  = '0;
    if (is_fwd) sub_delta = SUB_WIDE_W'(1);
    if (is_rev) sub_delta = '1;
    sub_wide   = {sub_q[SUBSTEP_W-1], sub_q} + sub_delta;
    enter_s00  = (state_d == S00) && (state_d != state_q) && !is_illegal;
    detent_inc = enter_s00 && (sub_wide == DETENT_FWD);
    detent_dec = enter_s00 && (sub_wide == DETENT_REV);
    if (is_illegal || enter_s00) sub_d = '0;
    else                         sub_d = sub_wide[SUBSTEP_W-1:0];
  end

  // Outputs: clear overrides any coincident step on the counter only.
  always_comb begin
    pos_d = position;
    if (detent_inc)      pos_d = pos_up(position);
    else if (detent_dec) pos_d = pos_down(position);
    if (clear) pos_d = '0;
    dir_d = step_dir;
    if (detent_inc) dir_d = DIR_INC;
    if (detent_dec) dir_d = DIR_DEC;
    at_limit_d = (SATURATE != 0) && ((pos_d == '0) || (pos_d == POS_MAX));
  end

  // ---- stage p3: FSM state and registered strobes ----
  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      state_q    <= S00;
      sub_q      <= '0;
      position   <= '0;
      step_valid <= 1'b0;
      step_dir   <= DIR_INC;
      quad_err   <= 1'b0;
      press      <= 1'b0;
      sw_prev    <= 1'b0;
      at_limit   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      position   <= pos_d;
      step_valid <= detent_inc | detent_dec;
      step_dir   <= dir_d;
      quad_err   <= is_illegal;
      press      <= deb_p2[IDX_SW] & ~sw_prev;
      sw_prev    <= deb_p2[IDX_SW];
      at_limit   <= at_limit_d;
    end
  end

  assign switch_level = deb_p2[IDX_SW];

endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder front end. Holds the shared sample-tick
// divider and instantiates one quad_encoder_channel per encoder.
// Ports:
//   clk100Mhz : system clock
//   reset     : synchronous active-high reset
//   enc       : quad_encoder_if slave (raw inputs, clear, decoded outputs;
//               channel n position at [n*COUNT_WIDTH +: COUNT_WIDTH])
module quad_encoder_array
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int COUNT_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLOCK_DIVIDER   = 1,
  parameter int SATURATE        = 0
) (
  input  logic           clk100Mhz,
  input  logic           reset,
  quad_encoder_if.slave  enc
);

  localparam int DIV_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // With CLOCK_DIVIDER=1 the counter stays at 0 and tick is permanently high.
  always_ff @(posedge clk100Mhz) begin
    if (reset)                 div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    quad_encoder_channel #(
      .COUNT_WIDTH     (COUNT_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SATURATE        (SATURATE)
    ) u_chan (
      .clk100Mhz    (clk100Mhz),
      .reset        (reset),
      .tick         (tick),
      .enc_phase_a  (enc.enc_phase_a[g]),
      .enc_phase_b  (enc.enc_phase_b[g]),
      .enc_switch   (enc.enc_switch[g]),
      .clear        (enc.clear[g]),
      .position     (enc.position[g*COUNT_WIDTH +: COUNT_WIDTH]),
      .step_valid   (enc.step_valid[g]),
      .step_dir     (enc.step_dir[g]),
      .press        (enc.press[g]),
      .switch_level (enc.switch_level[g]),
      .quad_err     (enc.quad_err[g]),
      .at_limit     (enc.at_limit[g])
    );
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: dut0 wraps (SATURATE=0), dut1 saturates.
module tb_quad_encoder_array;

  localparam int CH   = 2;
  localparam int CW   = 8;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   tests_run = 0;
  int   tests_failed = 0;

  int n_step0 [CH] = '{0, 0};
  int n_err0  [CH] = '{0, 0};
  int n_prs0  [CH] = '{0, 0};
  int n_step1 [CH] = '{0, 0};
  int n_err1  [CH] = '{0, 0};

  always #5 clk = ~clk;

  quad_encoder_if #(.CHANNELS(CH), .COUNT_WIDTH(CW)) bus0 ();
  quad_encoder_if #(.CHANNELS(CH), .COUNT_WIDTH(CW)) bus1 ();

  quad_encoder_array #(.CHANNELS(CH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(4),
                       .CLOCK_DIVIDER(1), .SATURATE(0))
    dut0 (.clk100Mhz(clk), .reset(rst0), .enc(bus0));

  quad_encoder_array #(.CHANNELS(CH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(4),
                       .CLOCK_DIVIDER(1), .SATURATE(1))
    dut1 (.clk100Mhz(clk), .reset(rst1), .enc(bus1));

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      n_step0[i] += int'(bus0.step_valid[i]);
      n_err0[i]  += int'(bus0.quad_err[i]);
      n_prs0[i]  += int'(bus0.press[i]);
      n_step1[i] += int'(bus1.step_valid[i]);
      n_err1[i]  += int'(bus1.quad_err[i]);
    end
  end

  // Quadrature index 0..3 = S00, S10, S11, S01 (increment order).
  function automatic logic ga(int idx); return (idx == 1) || (idx == 2); endfunction
  function automatic logic gb(int idx); return (idx == 2) || (idx == 3); endfunction

  function automatic logic [CW-1:0] pos0(int ch); return bus0.position[ch*CW +: CW]; endfunction
  function automatic logic [CW-1:0] pos1(int ch); return bus1.position[ch*CW +: CW]; endfunction

  task automatic hold(int n); repeat (n) @(negedge clk); endtask

  task automatic drive0(int ch, int idx);
    bus0.enc_phase_a[ch] = ga(idx);
    bus0.enc_phase_b[ch] = gb(idx);
  endtask

  task automatic drive1(int ch, int idx);
    bus1.enc_phase_a[ch] = ga(idx);
    bus1.enc_phase_b[ch] = gb(idx);
  endtask

  task automatic reset_all;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.enc_phase_a = '0; bus0.enc_phase_b = '0; bus0.enc_switch = '0; bus0.clear = '0;
    bus1.enc_phase_a = '0; bus1.enc_phase_b = '0; bus1.enc_switch = '0; bus1.clear = '0;
    hold(4);
  endtask

  task automatic test_reset;
    reset_all();
    tests_run++;
    if (bus0.position !== '0) begin tests_failed++;
      $display("FAIL reset_pos0: got %h want 0", bus0.position); end
    tests_run++;
    if ({bus0.step_valid, bus0.step_dir, bus0.press, bus0.switch_level, bus0.quad_err, bus0.at_limit} !== 12'h0) begin
      tests_failed++; $display("FAIL reset_out0: strobes not all zero"); end
    tests_run++;
    if (bus1.position !== '0) begin tests_failed++;
      $display("FAIL reset_pos1: got %h want 0", bus1.position); end
    tests_run++;
    if ({bus1.step_valid, bus1.step_dir, bus1.press, bus1.switch_level, bus1.quad_err, bus1.at_limit} !== 12'h0) begin
      tests_failed++; $display("FAIL reset_out1: strobes not all zero"); end
    rst0 = 1'b0; rst1 = 1'b0;
    hold(3);
    tests_run++;
    if (bus1.at_limit !== 2'b11) begin tests_failed++;
      $display("FAIL sat_limit_zero: got %b want 11", bus1.at_limit); end
    tests_run++;
    if (bus0.at_limit !== 2'b00) begin tests_failed++;
      $display("FAIL wrap_no_limit: got %b want 00", bus0.at_limit); end
  endtask

  task automatic test_wrap_dec;
    int s0 = n_step0[0], s1 = n_step0[1];
    for (int c = 0; c < 3; c++)
      for (int k = 3; k >= 0; k--) begin drive0(0, k); hold(HOLD); end
    tests_run++;
    if (n_step0[0] - s0 !== 3) begin tests_failed++;
      $display("FAIL dec_steps: got %0d want 3", n_step0[0] - s0); end
    tests_run++;
    if (pos0(0) !== 8'hFD) begin tests_failed++;
      $display("FAIL dec_wrap_pos: got %h want fd", pos0(0)); end
    tests_run++;
    if (bus0.step_dir[0] !== 1'b1) begin tests_failed++;
      $display("FAIL dec_dir: got %b want 1", bus0.step_dir[0]); end
    tests_run++;
    if (pos0(1) !== 8'h00 || n_step0[1] !== s1) begin tests_failed++;
      $display("FAIL dec_ch1_idle: pos %h steps %0d want 00 0", pos0(1), n_step0[1] - s1); end
  endtask

  task automatic test_inc_clear;
    int s1 = n_step0[1];
    for (int c = 0; c < 3; c++)
      for (int k = 1; k <= 4; k++) begin drive0(1, k % 4); hold(HOLD); end
    tests_run++;
    if (pos0(1) !== 8'h03) begin tests_failed++;
      $display("FAIL inc_pos: got %h want 03", pos0(1)); end
    tests_run++;
    if (bus0.step_dir[1] !== 1'b0) begin tests_failed++;
      $display("FAIL inc_dir: got %b want 0", bus0.step_dir[1]); end
    for (int k = 1; k <= 3; k++) begin drive0(1, k); hold(HOLD); end
    drive0(1, 0);
    hold(6);
    tests_run++;
    if (bus0.step_valid[1] !== 1'b0) begin tests_failed++;
      $display("FAIL step_early: got %b want 0", bus0.step_valid[1]); end
    bus0.clear[1] = 1'b1;
    hold(1);
    bus0.clear[1] = 1'b0;
    tests_run++;
    if (bus0.step_valid[1] !== 1'b1) begin tests_failed++;
      $display("FAIL step_latency: got %b want 1", bus0.step_valid[1]); end
    tests_run++;
    if (pos0(1) !== 8'h00) begin tests_failed++;
      $display("FAIL clear_wins: got %h want 00", pos0(1)); end
    hold(HOLD);
    tests_run++;
    if (n_step0[1] - s1 !== 4) begin tests_failed++;
      $display("FAIL clear_steps: got %0d want 4", n_step0[1] - s1); end
    tests_run++;
    if (pos0(0) !== 8'hFD) begin tests_failed++;
      $display("FAIL clear_other_ch: got %h want fd", pos0(0)); end
  endtask

  task automatic test_saturate;
    int s0 = n_step1[0];
    for (int c = 0; c < 2; c++)
      for (int k = 3; k >= 0; k--) begin drive1(0, k); hold(8); end
    tests_run++;
    if (pos1(0) !== 8'h00 || n_step1[0] - s0 !== 2) begin tests_failed++;
      $display("FAIL sat_low: pos %h steps %0d want 00 2", pos1(0), n_step1[0] - s0); end
    tests_run++;
    if (bus1.at_limit[0] !== 1'b1 || bus1.step_dir[0] !== 1'b1) begin tests_failed++;
      $display("FAIL sat_low_flags: limit %b dir %b want 1 1", bus1.at_limit[0], bus1.step_dir[0]); end
    s0 = n_step1[0];
    for (int c = 0; c < 256; c++) begin
      for (int k = 1; k <= 4; k++) begin drive1(0, k % 4); hold(8); end
      if (c == 0) begin
        tests_run++;
        if (pos1(0) !== 8'h01 || bus1.at_limit[0] !== 1'b0) begin tests_failed++;
          $display("FAIL sat_leave: pos %h limit %b want 01 0", pos1(0), bus1.at_limit[0]); end
      end
    end
    tests_run++;
    if (pos1(0) !== 8'hFF || n_step1[0] - s0 !== 256) begin tests_failed++;
      $display("FAIL sat_high: pos %h steps %0d want ff 256", pos1(0), n_step1[0] - s0); end
    tests_run++;
    if (bus1.at_limit[0] !== 1'b1 || bus1.step_dir[0] !== 1'b0) begin tests_failed++;
      $display("FAIL sat_high_flags: limit %b dir %b want 1 0", bus1.at_limit[0], bus1.step_dir[0]); end
  endtask

  task automatic test_half_turn_glitch;
    int s0 = n_step0[0], e0 = n_err0[0], p0 = n_prs0[0];
    int seq [4] = '{1, 2, 1, 0};
    logic saw_level = 1'b0;
    foreach (seq[i]) begin drive0(0, seq[i]); hold(HOLD); end
    tests_run++;
    if (n_step0[0] !== s0 || n_err0[0] !== e0 || pos0(0) !== 8'hFD) begin tests_failed++;
      $display("FAIL half_turn: steps %0d errs %0d pos %h want 0 0 fd", n_step0[0] - s0, n_err0[0] - e0, pos0(0)); end
    bus0.enc_phase_a[0] = 1'b1; bus0.enc_phase_b[0] = 1'b1; bus0.enc_switch[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin hold(1); saw_level |= bus0.switch_level[0]; end
    bus0.enc_phase_a[0] = 1'b0; bus0.enc_phase_b[0] = 1'b0; bus0.enc_switch[0] = 1'b0;
    for (int i = 0; i < HOLD; i++) begin hold(1); saw_level |= bus0.switch_level[0]; end
    tests_run++;
    if (n_err0[0] !== e0 || saw_level !== 1'b0 || n_prs0[0] !== p0) begin tests_failed++;
      $display("FAIL glitch3: errs %0d level %b presses %0d want 0 0 0", n_err0[0] - e0, saw_level, n_prs0[0] - p0); end
    bus0.enc_switch[0] = 1'b1;
    hold(4);
    bus0.enc_switch[0] = 1'b0;
    hold(HOLD + 4);
    tests_run++;
    if (n_prs0[0] - p0 !== 1) begin tests_failed++;
      $display("FAIL pulse4_passes: presses %0d want 1", n_prs0[0] - p0); end
  endtask

  task automatic test_illegal;
    int s0 = n_step0[0], e0 = n_err0[0];
    drive0(0, 2);
    hold(6);
    tests_run++;
    if (bus0.quad_err[0] !== 1'b0) begin tests_failed++;
      $display("FAIL err_early: got %b want 0", bus0.quad_err[0]); end
    hold(1);
    tests_run++;
    if (bus0.quad_err[0] !== 1'b1) begin tests_failed++;
      $display("FAIL err_latency: got %b want 1", bus0.quad_err[0]); end
    hold(1);
    tests_run++;
    if (bus0.quad_err[0] !== 1'b0) begin tests_failed++;
      $display("FAIL err_width: got %b want 0", bus0.quad_err[0]); end
    hold(HOLD);
    drive0(0, 0);
    hold(HOLD);
    tests_run++;
    if (n_err0[0] - e0 !== 2 || n_step0[0] !== s0 || pos0(0) !== 8'hFD) begin tests_failed++;
      $display("FAIL err_nostep: errs %0d steps %0d pos %h want 2 0 fd", n_err0[0] - e0, n_step0[0] - s0, pos0(0)); end
  endtask

  task automatic test_switch_and_reset;
    int p0 = n_prs0[0], s0, e0;
    bus0.enc_switch[0] = 1'b1;
    hold(5);
    tests_run++;
    if (bus0.switch_level[0] !== 1'b0) begin tests_failed++;
      $display("FAIL level_early: got %b want 0", bus0.switch_level[0]); end
    hold(1);
    tests_run++;
    if (bus0.switch_level[0] !== 1'b1) begin tests_failed++;
      $display("FAIL level_latency: got %b want 1", bus0.switch_level[0]); end
    hold(1);
    tests_run++;
    if (bus0.press[0] !== 1'b1) begin tests_failed++;
      $display("FAIL press_latency: got %b want 1", bus0.press[0]); end
    hold(43);
    bus0.enc_switch[0] = 1'b0;
    hold(HOLD);
    tests_run++;
    if (n_prs0[0] - p0 !== 1 || bus0.switch_level[0] !== 1'b0) begin tests_failed++;
      $display("FAIL press_once: presses %0d level %b want 1 0", n_prs0[0] - p0, bus0.switch_level[0]); end
    drive0(0, 1); hold(HOLD);
    drive0(0, 2); hold(HOLD);
    rst0 = 1'b1;
    hold(3);
    tests_run++;
    if (bus0.position !== '0 ||
        {bus0.step_valid, bus0.step_dir, bus0.press, bus0.switch_level, bus0.quad_err, bus0.at_limit} !== 12'h0) begin
      tests_failed++; $display("FAIL midrot_reset: pos %h not all outputs zero", bus0.position); end
    rst0 = 1'b0;
    s0 = n_step0[0]; e0 = n_err0[0];
    hold(HOLD + 2);
    drive0(0, 3); hold(HOLD);
    drive0(0, 0); hold(HOLD);
    tests_run++;
    if (n_step0[0] !== s0 || pos0(0) !== 8'h00) begin tests_failed++;
      $display("FAIL midrot_nostep: steps %0d pos %h want 0 00", n_step0[0] - s0, pos0(0)); end
    tests_run++;
    if (n_err0[0] - e0 !== 1) begin tests_failed++;
      $display("FAIL midrot_jump_err: errs %0d want 1", n_err0[0] - e0); end
  endtask

  task automatic test_back_to_back_random;
    int   m_idx [CH], m_sub [CH], m_pw [CH], m_ps [CH], m_step [CH], m_err [CH];
    int   b_s0 [CH], b_s1 [CH], b_e0 [CH], b_e1 [CH];
    logic m_dir [CH];
    reset_all();
    rst0 = 1'b0; rst1 = 1'b0;
    hold(3);
    for (int c = 0; c < CH; c++) begin
      m_idx[c] = 0; m_sub[c] = 0; m_pw[c] = 0; m_ps[c] = 0; m_step[c] = 0; m_err[c] = 0;
      m_dir[c] = 1'b0;
      b_s0[c] = n_step0[c]; b_s1[c] = n_step1[c]; b_e0[c] = n_err0[c]; b_e1[c] = n_err1[c];
    end
    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < CH; c++) begin
        int r, d, nidx;
        r = int'($urandom_range(0, 9));
        d = (r < 4) ? 1 : (r < 8) ? 3 : (r == 8) ? 2 : 0;
        nidx = (m_idx[c] + d) % 4;
        drive0(c, nidx); drive1(c, nidx);
        if (d == 1) m_sub[c]++;
        else if (d == 3) m_sub[c]--;
        else if (d == 2) begin m_err[c]++; m_sub[c] = 0; end
        if (d != 0 && nidx == 0) begin
          if (m_sub[c] == 4) begin
            m_step[c]++; m_dir[c] = 1'b0;
            m_pw[c] = (m_pw[c] + 1) % 256;
            m_ps[c] = (m_ps[c] == 255) ? 255 : m_ps[c] + 1;
          end else if (m_sub[c] == -4) begin
            m_step[c]++; m_dir[c] = 1'b1;
            m_pw[c] = (m_pw[c] + 255) % 256;
            m_ps[c] = (m_ps[c] == 0) ? 0 : m_ps[c] - 1;
          end
          m_sub[c] = 0;
        end
        m_idx[c] = nidx;
      end
      hold(HOLD);
      if ($urandom_range(0, 5) == 0) begin
        int cc;
        cc = int'($urandom_range(0, CH - 1));
        bus0.clear[cc] = 1'b1; bus1.clear[cc] = 1'b1;
        hold(1);
        bus0.clear[cc] = 1'b0; bus1.clear[cc] = 1'b0;
        hold(1);
        m_pw[cc] = 0; m_ps[cc] = 0;
      end
      for (int c = 0; c < CH; c++) begin
        tests_run++;
        if (pos0(c) !== CW'(m_pw[c])) begin tests_failed++;
          $display("FAIL rnd_wrap_pos it%0d ch%0d: got %h want %h", it, c, pos0(c), CW'(m_pw[c])); end
        tests_run++;
        if (pos1(c) !== CW'(m_ps[c])) begin tests_failed++;
          $display("FAIL rnd_sat_pos it%0d ch%0d: got %h want %h", it, c, pos1(c), CW'(m_ps[c])); end
        tests_run++;
        if (n_step0[c] - b_s0[c] !== m_step[c] || n_step1[c] - b_s1[c] !== m_step[c]) begin tests_failed++;
          $display("FAIL rnd_steps it%0d ch%0d: got %0d/%0d want %0d", it, c,
                   n_step0[c] - b_s0[c], n_step1[c] - b_s1[c], m_step[c]); end
        tests_run++;
        if (n_err0[c] - b_e0[c] !== m_err[c] || n_err1[c] - b_e1[c] !== m_err[c]) begin tests_failed++;
          $display("FAIL rnd_errs it%0d ch%0d: got %0d/%0d want %0d", it, c,
                   n_err0[c] - b_e0[c], n_err1[c] - b_e1[c], m_err[c]); end
        tests_run++;
        if (bus0.step_dir[c] !== m_dir[c]) begin tests_failed++;
          $display("FAIL rnd_dir it%0d ch%0d: got %b want %b", it, c, bus0.step_dir[c], m_dir[c]); end
        tests_run++;
        if (bus1.at_limit[c] !== ((m_ps[c] == 0) || (m_ps[c] == 255))) begin tests_failed++;
          $display("FAIL rnd_limit it%0d ch%0d: got %b pos %0d", it, c, bus1.at_limit[c], m_ps[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_dec();
    test_inc_clear();
    test_saturate();
    test_half_turn_glitch();
    test_illegal();
    test_switch_and_reset();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/quad_encoder_array.md
Name: quad_encoder_array

Overview:
Multi-channel, parametrised quadrature rotary-encoder front end for the Motherboard top level.
- Synchronises, debounces and decodes CHANNELS encoders (phase A, phase B, push switch).
- Keeps a per-channel detent position counter with selectable wrap or saturate mode.
- Emits single-cycle step, direction, press and error strobes for downstream logic (LED display, menu FSMs).

Parameters:
CHANNELS, 2, number of independent encoders
COUNT_WIDTH, 8, bits per position counter
DEBOUNCE_CYCLES, 4, consecutive identical sample ticks (>=1) required before a debounced input changes
CLOCK_DIVIDER, 1, sample tick every CLOCK_DIVIDER clk100Mhz cycles (1 = every cycle)
SATURATE, 0, 0 = position wraps modulo 2^COUNT_WIDTH; 1 = clamps at 0 and 2^COUNT_WIDTH-1

Ports:
clk100Mhz  in  1  system clock; only clock
reset  in  1  synchronous, active-high reset
enc_phase_a  in  CHANNELS  raw phase A per channel, asynchronous
enc_phase_b  in  CHANNELS  raw phase B per channel, asynchronous
enc_switch  in  CHANNELS  raw push switch, active-high, asynchronous
clear  in  CHANNELS  synchronous per-channel position clear
position  out  CHANNELS*COUNT_WIDTH  packed counters; channel n at [n*COUNT_WIDTH +: COUNT_WIDTH]
step_valid  out  CHANNELS  1-cycle pulse per completed detent
step_dir  out  CHANNELS  direction of the last step: 0 = increment (A leads), 1 = decrement (B leads)
press  out  CHANNELS  1-cycle pulse on debounced switch rising edge
switch_level  out  CHANNELS  debounced switch level
quad_err  out  CHANNELS  1-cycle pulse on an illegal quadrature transition
at_limit  out  CHANNELS  high while position is at 0 or at max (SATURATE=1 only; otherwise 0)

Behaviour:
- Reset: a single clock and a synchronous active-high reset named reset. While reset is high, every output is 0. Synchronisers, debouncers, divider, sub-step counters and FSM state are cleared; debounced A/B/switch are 0. Reset mid-rotation discards any partial detent.
- Input path: 2-FF synchroniser on every raw input, then a divider producing a tick every CLOCK_DIVIDER cycles.
- Debounce: on each tick, a debounced bit updates only after its synchronised value has differed from the current debounced value for DEBOUNCE_CYCLES consecutive ticks. Any tick that matches resets that bit's run counter.
- Latency (CLOCK_DIVIDER=1): 2 + DEBOUNCE_CYCLES cycles from raw edge to debounced edge.
- Quadrature FSM per channel: state is the debounced {A,B}, one of S00, S10, S11, S01.
  - Increment sequence: S00->S10->S11->S01->S00. Each forward edge adds +1 to a signed sub-step counter (range -4..+4).
  - Reverse sequence adds -1.
  - Two-bit change in one tick: illegal. Pulse quad_err, clear the sub-step counter, adopt the new state.
- Detent: on entry to S00, with the next cycle being registered:
  - sub-step = +4: step_valid=1, step_dir=0, position+1.
  - sub-step = -4: step_valid=1, step_dir=1, position-1.
  - Otherwise (partial turn or bounce-back): no step.
  - In all cases, clear the sub-step counter.
- Position update: happens in the same cycle step_valid is asserted, i.e. one cycle after the debounced S00 entry.
- Wrap (SATURATE=0): 2^COUNT_WIDTH-1 +1 -> 0 and 0 -1 -> 2^COUNT_WIDTH-1.
- Saturate (SATURATE=1): the counter holds at its bound. step_valid still pulses; at_limit=1 while at a bound.
- clear: sets that channel's position to 0 next cycle. If clear and a step coincide, clear wins and step_valid still pulses. Other channels are unaffected.
- step_dir holds its value until the next step.
- press: pulses one cycle after a debounced switch 0->1. No pulse on release. Held switch gives exactly one pulse.
- Channel independence: channels are fully independent; simultaneous events on all channels are each handled in the same cycle.

Decomposition:
- Package quad_encoder_pkg:
  - quad state encoding (S00/S10/S11/S01);
  - DIR_INC=0, DIR_DEC=1;
  - SUBSTEPS_PER_DETENT=4;
  - sub-step counter width (3 bits signed).
- Sub-module quad_encoder_channel: synchroniser, debouncer, FSM and counter for one channel, instantiated CHANNELS times via generate.
- The shared tick divider lives in the top level.

Test Plan (CHANNELS=2, COUNT_WIDTH=8, DEBOUNCE_CYCLES=4, CLOCK_DIVIDER=1; each phase level held >=8 cycles):
1. Pulse reset, then drive 3 full B-leading cycles on ch0, SATURATE=0 -> 3 step_valid pulses, step_dir=1, ch0 position 0xFD; ch1 stays 0.
2. 3 full A-leading cycles on ch1 from 0 -> position 0x03, step_dir=0. Then assert clear[1] in the same cycle as a 4th step -> position 0x00, step_valid pulses once.
3. SATURATE=1: 2 B-leading cycles from 0 -> position 0, 2 step_valid pulses, at_limit=1. Repeat with 256 A-leading cycles -> position 0xFF, at_limit=1.
4. Half turn S00->S10->S11, then back S10->S00 -> no step_valid, no quad_err, position unchanged. A 3-cycle glitch on phase A -> no debounced change.
5. Jump S00->S11 (both phases together) -> quad_err one-cycle pulse 2+4+1 cycles after the edge; no step.
6. Hold enc_switch high 50 cycles -> press exactly once, switch_level=1 from cycle 6 after the edge. Assert reset mid-rotation (at S11) -> all outputs 0; the subsequent completion to S00 produces no step.
